// File: rtl/jt12_lfo_gen_if.sv
// Signal bundle between the YM2612 timing/register logic and the LFO.
// The master drives the timing strobes and register fields; the slave returns the modulation words.
interface jt12_lfo_gen_if;
    logic       clk_en;
    logic       zero;
    logic       lfo_en;
    logic [2:0] lfo_freq;
    logic [6:0] lfo_am;
    logic [4:0] lfo_pm;
    logic       lfo_step;

    modport master (
        output clk_en,
        output zero,
        output lfo_en,
        output lfo_freq,
        input  lfo_am,
        input  lfo_pm,
        input  lfo_step
    );

    modport slave (
        input  clk_en,
        input  zero,
        input  lfo_en,
        input  lfo_freq,
        output lfo_am,
        output lfo_pm,
        output lfo_step
    );
endinterface

// File: rtl/jt12_lfo_gen.sv
// YM2612 low-frequency oscillator: sample-rate divider, 7-bit phase counter,
// and triangle shaping into the AM depth word and the PM index.
module jt12_lfo_gen (
    input  logic          clk,
    input  logic          rst,
    jt12_lfo_gen_if.slave bus
);

    // Last divider value before a step, i.e. L-1 for each rate select.
    function automatic logic [6:0] rate_last(input logic [2:0] freq);
        logic [6:0] last_v;
        case (freq)
            3'd0:    last_v = 7'd107;
            3'd1:    last_v = 7'd76;
            3'd2:    last_v = 7'd70;
            3'd3:    last_v = 7'd66;
            3'd4:    last_v = 7'd61;
            3'd5:    last_v = 7'd43;
            3'd6:    last_v = 7'd7;
            3'd7:    last_v = 7'd4;
            default: last_v = 7'd107;
        endcase
        return last_v;
    endfunction

    // Fold the upper half of the phase back down to form a triangle.
    function automatic logic [5:0] tri_shape(input logic [6:0] cnt);
        logic [5:0] shape_v;
        if (cnt[6]) begin
            shape_v = ~cnt[5:0];
        end else begin
            shape_v = cnt[5:0];
        end
        return shape_v;
    endfunction

    logic [6:0] div_cnt_r;
    logic [6:0] lfo_cnt_r;
    logic [6:0] lfo_am_r;
    logic [4:0] lfo_pm_r;
    logic       lfo_step_r;
    logic [6:0] div_last_s;
    logic       div_wrap_s;

    // Greater-or-equal compare so a rate drop below the current count steps immediately.
    always_comb begin
        div_last_s = rate_last(bus.lfo_freq);
        if (div_cnt_r >= div_last_s) begin
            div_wrap_s = 1'b1;
        end else begin
            div_wrap_s = 1'b0;
        end
    end

    // Sample divider, phase counter and step pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r  <= 7'd0;
            lfo_cnt_r  <= 7'd0;
            lfo_step_r <= 1'b0;
        end else if (bus.clk_en) begin
            if (!bus.lfo_en) begin
                div_cnt_r  <= 7'd0;
                lfo_cnt_r  <= 7'd0;
                lfo_step_r <= 1'b0;
            end else if (bus.zero) begin
                if (div_wrap_s) begin
                    div_cnt_r  <= 7'd0;
                    lfo_cnt_r  <= lfo_cnt_r + 7'd1;
                    lfo_step_r <= 1'b1;
                end else begin
                    div_cnt_r  <= div_cnt_r + 7'd1;
                    lfo_step_r <= 1'b0;
                end
            end else begin
                lfo_step_r <= 1'b0;
            end
        end
    end

    // Output words follow the phase counter one enabled cycle late.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfo_am_r <= 7'd0;
            lfo_pm_r <= 5'd0;
        end else if (bus.clk_en) begin
            lfo_am_r <= {tri_shape(lfo_cnt_r), 1'b0};
            lfo_pm_r <= lfo_cnt_r[6:2];
        end
    end

    assign bus.lfo_am   = lfo_am_r;
    assign bus.lfo_pm   = lfo_pm_r;
    assign bus.lfo_step = lfo_step_r;

endmodule

// File: doc/jt12_lfo_gen.md
# jt12_lfo_gen

Low-frequency oscillator for the YM2612 core. It produces the amplitude-modulation word `lfo_am` consumed by the envelope generator's AM input and the phase-modulation index `lfo_pm` consumed by the phase generator. It advances once per output sample, gated by the sample-boundary strobe `zero`, at one of eight programmable rates. It sits upstream of the envelope generator and is shared by all 24 operator slots.

## Interface
Parameters:
- none; the rate table is fixed (see Operation).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `clk_en`  in  1  clock enable; all state updates are qualified by it.
- `zero`  in  1  sample-boundary strobe, high for one `clk_en` cycle out of every 24 slots.
- `lfo_en`  in  1  LFO enable (register 0x22 bit 3).
- `lfo_freq`  in  3  rate select (register 0x22 bits 2:0).
- `lfo_am`  out  7  AM depth word.
  - Even values 0..126.
  - Feeds the envelope generator `am` input.
- `lfo_pm`  out  5  PM index (0..31) for the phase generator.
- `lfo_step`  out  1  one-`clk_en`-cycle pulse when the phase counter advances.

## Operation
- State:
  - `div_cnt`: 7-bit sample divider.
  - `lfo_cnt`: 7-bit LFO phase, 128 steps per period.
- Rate limit L(`lfo_freq`), in samples per step: 0→108, 1→77, 2→71, 3→67, 4→62, 5→44, 6→8, 7→5.
- On each cycle where `clk_en && zero && lfo_en`:
  - If `div_cnt >= L-1`: `div_cnt`←0, `lfo_cnt`←`lfo_cnt`+1 (7-bit, wraps 127→0), and `lfo_step` pulses.
  - Else: `div_cnt`←`div_cnt`+1.
- The compare is `>=`, not `==`. Lowering `lfo_freq` below the current `div_cnt` therefore causes an immediate step at the next `zero`; there is no 128-sample stall.
- On any `clk_en` cycle with `lfo_en`=0: `div_cnt`←0 and `lfo_cnt`←0. This applies regardless of `zero`.
- Triangle shaping:
  - `tri[5:0]` = `lfo_cnt[6] ? ~lfo_cnt[5:0] : lfo_cnt[5:0]`.
  - `lfo_am` = {`tri`, 1'b0}.
  - `lfo_pm` = `lfo_cnt[6:2]`.
- `lfo_am` and `lfo_pm` are registered from `lfo_cnt` on every `clk_en` cycle.
- Arithmetic: all counters are unsigned. No saturation is needed; only `lfo_cnt` wraps.

## Timing
- Reset values: `div_cnt`=0, `lfo_cnt`=0, `lfo_am`=0, `lfo_pm`=0, `lfo_step`=0.
- `lfo_cnt` changes on the edge where `clk_en && zero` is sampled.
- `lfo_step` is registered high on that same edge and drops on the next `clk_en` edge.
- `lfo_am` and `lfo_pm` reflect the new `lfo_cnt` one `clk_en` cycle after that edge. They then stay constant for the remaining 23 slots of the sample.
- While `clk_en`=0, all registers hold, including a high `lfo_step`.
- Disable mid-period: the counters are zero after the first `clk_en` edge with `lfo_en`=0. The outputs reach 0 one `clk_en` cycle later.
- Re-enable: the first step occurs L samples after the first `zero` with `lfo_en`=1. For example, with `lfo_freq`=7, the 5th `zero` produces the step.
- `rst` during operation overrides `clk_en`: all state clears on that edge.
- A `lfo_freq` change takes effect at the next `zero` evaluation. There is no pipeline delay.

## Test plan
- Reset: assert `rst` with `clk_en`=1 for 2 cycles → `lfo_am`=0, `lfo_pm`=0, `lfo_step`=0. Outputs stay 0 with `lfo_en`=0 over 1000 samples.
- `lfo_en`=1, `lfo_freq`=7: `lfo_step` pulses once every 5 `zero` strobes.
  - After 63 steps: `lfo_am`=126, `lfo_pm`=15.
  - After 64 steps: `lfo_am`=126, `lfo_pm`=16.
  - After 127 steps: `lfo_am`=0.
  - After 128 steps (640 samples): wraps to `lfo_cnt`=0.
- `lfo_freq`=0: 108 samples between consecutive `lfo_step` pulses; a full period is 13824 samples. Check each rate 1..6 for its L.
- Rate drop: `lfo_freq`=0 with `div_cnt`=50, then switch to 6 → step on the very next `zero`. The following step comes 8 samples later.
- Disable mid-run at `lfo_cnt`=90: the next `clk_en` clears the counters, the outputs read 0 one `clk_en` later, and no `lfo_step` occurs while disabled. After re-enable with `lfo_freq`=7, the first step is on the 5th `zero`.
- `clk_en` toggling at 1/2 rate with `zero` held high across a gated cycle → exactly one increment per qualified `zero`. Outputs are unchanged during `clk_en`=0 cycles.
